// File: rtl/alarme_ctrl.sv
// Alarm controller: synchronises three sensors, votes 2-of-3, debounces the vote and
// sequences arm / entry delay / siren / latched-alarm with registered status outputs.
module alarme_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ENTRY_DELAY     = 16,
  parameter int SIREN_TIME      = 64,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       arm,
  input  logic       disarm,
  output logic       armed,
  output logic       pending,
  output logic       siren,
  output logic       alarm_mem,
  output logic       arm_err,
  output logic [2:0] state
);

  localparam logic [2:0] S_DISARMED = 3'd0;
  localparam logic [2:0] S_ARMED    = 3'd1;
  localparam logic [2:0] S_ENTRY    = 3'd2;
  localparam logic [2:0] S_SIREN    = 3'd3;
  localparam logic [2:0] S_LATCHED  = 3'd4;

  localparam int               DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  logic [2:0]       sync1_q, sync2_q;
  logic             trig_raw_s;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             trig_db_q, trig_db_d;
  logic             trig_prev_q;
  logic             trig_rise_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             arm_err_d;
  logic             armed_q, pending_q, siren_q, alarm_mem_q, arm_err_q;

  assign trig_raw_s  = maj3(sync2_q);
  assign trig_rise_s = trig_db_q & ~trig_prev_q;

  // A mismatch must persist for DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
  always_comb begin
    db_cnt_d  = db_cnt_q;
    trig_db_d = trig_db_q;
    if (trig_raw_s != trig_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        trig_db_d = trig_raw_s;
        db_cnt_d  = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    arm_err_d = 1'b0;
    if (disarm) begin
      state_d = S_DISARMED;
    end else begin
      case (state_q)
        S_DISARMED: begin
          if (arm && trig_db_q) begin
            arm_err_d = 1'b1;
          end else if (arm) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_DISARMED;
          end
        end
        S_ARMED: begin
          if (trig_db_q) begin
            state_d = S_ENTRY;
            timer_d = ENTRY_LOAD;
          end else begin
            state_d = S_ARMED;
          end
        end
        S_ENTRY: begin
          if (timer_q == '0) begin
            state_d = S_SIREN;
            timer_d = SIREN_LOAD;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        S_SIREN: begin
          if (timer_q == '0) begin
            state_d = S_LATCHED;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        S_LATCHED: begin
          // Only a fresh trigger re-opens the entry window, not a trigger still held from before.
          if (trig_rise_s) begin
            state_d = S_ENTRY;
            timer_d = ENTRY_LOAD;
          end else begin
            state_d = S_LATCHED;
          end
        end
        default: begin
          state_d = S_DISARMED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 3'b000;
      sync2_q     <= 3'b000;
      db_cnt_q    <= '0;
      trig_db_q   <= 1'b0;
      trig_prev_q <= 1'b0;
      state_q     <= S_DISARMED;
      timer_q     <= '0;
      armed_q     <= 1'b0;
      pending_q   <= 1'b0;
      siren_q     <= 1'b0;
      alarm_mem_q <= 1'b0;
      arm_err_q   <= 1'b0;
    end else begin
      sync1_q     <= {C, B, A};
      sync2_q     <= sync1_q;
      db_cnt_q    <= db_cnt_d;
      trig_db_q   <= trig_db_d;
      trig_prev_q <= trig_db_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      armed_q     <= (state_d != S_DISARMED);
      pending_q   <= (state_d == S_ENTRY);
      siren_q     <= (state_d == S_SIREN);
      alarm_mem_q <= (state_d == S_LATCHED);
      arm_err_q   <= arm_err_d;
    end
  end

  assign armed     = armed_q;
  assign pending   = pending_q;
  assign siren     = siren_q;
  assign alarm_mem = alarm_mem_q;
  assign arm_err   = arm_err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_alarme_ctrl.sv
// Bench for alarme_ctrl: directed scenarios plus random traffic, every cycle compared
// against an event/deadline-based reference model.
module tb_alarme_ctrl;

  localparam int DEB   = 4;
  localparam int ENTRY = 16;
  localparam int SIREN = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       A = 1'b0, B = 1'b0, C = 1'b0, arm = 1'b0, disarm = 1'b0;
  logic       armed, pending, siren, alarm_mem, arm_err;
  logic [2:0] state;

  int n_chk  = 0;
  int n_pass = 0;

  alarme_ctrl #(.DEBOUNCE_CYCLES(DEB), .ENTRY_DELAY(ENTRY), .SIREN_TIME(SIREN), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .arm(arm), .disarm(disarm),
    .armed(armed), .pending(pending), .siren(siren), .alarm_mem(alarm_mem),
    .arm_err(arm_err), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: majority delayed by the two sync stages, debounce as "last DEB
  // samples all disagree and no flip within them", FSM timed by absolute deadlines.
  logic m_in1, m_in2, m_db, m_dbp, m_err;
  bit   m_hist[$];
  int   m_n, m_last_flip, m_mode, m_t0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_in1 = 1'b0; m_in2 = 1'b0; m_db = 1'b0; m_dbp = 1'b0; m_err = 1'b0;
    m_hist.delete();
    m_n = 0; m_last_flip = -100; m_mode = 0; m_t0 = 0;
  endtask

  task automatic model_edge(input logic a, input logic b, input logic c, input logic ar, input logic di);
    logic raw, db_old, dbp_old;
    bit   all_diff;
    int   votes;
    raw   = m_in2;
    m_in2 = m_in1;
    votes = int'(a) + int'(b) + int'(c);
    m_in1 = (votes >= 2);
    db_old  = m_db;
    dbp_old = m_dbp;
    m_n++;
    m_hist.push_back(raw);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    all_diff = (m_hist.size() == DEB);
    foreach (m_hist[i]) if (m_hist[i] == db_old) all_diff = 1'b0;
    if (all_diff && (m_n - m_last_flip) >= DEB) begin
      m_db = ~db_old;
      m_last_flip = m_n;
    end
    m_err = 1'b0;
    if (di) m_mode = 0;
    else begin
      case (m_mode)
        0: if (ar) begin if (db_old) m_err = 1'b1; else m_mode = 1; end
        1: if (db_old) begin m_mode = 2; m_t0 = m_n; end
        2: if (m_n - m_t0 == ENTRY) begin m_mode = 3; m_t0 = m_n; end
        3: if (m_n - m_t0 == SIREN) m_mode = 4;
        4: if (db_old && !dbp_old) begin m_mode = 2; m_t0 = m_n; end
        default: m_mode = 0;
      endcase
    end
    m_dbp = db_old;
  endtask

  function automatic logic [7:0] dut_vec();
    return {state, armed, pending, siren, alarm_mem, arm_err};
  endfunction

  function automatic logic [7:0] exp_vec();
    return {3'(m_mode), (m_mode != 0), (m_mode == 2), (m_mode == 3), (m_mode == 4), m_err};
  endfunction

  task automatic cyc(input logic a, input logic b, input logic c, input logic ar, input logic di);
    @(negedge clk);
    A = a; B = b; C = c; arm = ar; disarm = di;
    @(posedge clk);
    model_edge(a, b, c, ar, di);
    #1;
    check_eq("cycle", 32'(dut_vec()), 32'(exp_vec()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int lat, ep, es, ea;
    bit siren_seen;
    logic ra, rb, rc;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vote: a single sensor never triggers; two sensors reach ENTRY after 7 edges
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("armed_state", 32'(state), 32'd1);
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("single_sensor", 32'(state), 32'd1);
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (pending) lat = k;
    end
    check_eq("pending_latency", 32'(lat), 32'd7);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(10);

    // Debounce: 3-cycle glitch is rejected
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    check_eq("glitch_state", 32'(state), 32'd1);

    // Full timeline from ARMED
    ep = -1; es = -1; ea = -1;
    for (int k = 1; k <= 100 && ea < 0; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      if (pending && ep < 0) ep = k;
      if (siren && es < 0) es = k;
      if (alarm_mem && ea < 0) ea = k;
    end
    check_eq("tl_pending", 32'(ep), 32'd7);
    check_eq("tl_siren", 32'(es), 32'd23);
    check_eq("tl_alarm_mem", 32'(ea), 32'd87);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("disarm_all_zero", 32'(dut_vec()), 32'd0);
    idle(10);

    // Disarm inside the entry window
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (pending) lat = k;
    end
    check_eq("window_pending", 32'(lat), 32'd7);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    siren_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (siren) siren_seen = 1'b1;
    end
    check_eq("window_no_siren", 32'(siren_seen), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("arm_and_disarm", 32'(state), 32'd0);

    // Arm refusal while the trigger is debounced high
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("arm_err_set", 32'({arm_err, state}), 32'({1'b1, 3'd0}));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("arm_err_pulse", 32'(arm_err), 32'd0);

    // LATCHED re-entry on a fresh trigger, then async reset in SIREN
    idle(10);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("latched", 32'(alarm_mem), 32'd1);
    idle(8);
    check_eq("latched_hold", 32'(state), 32'd4);
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (pending) lat = k;
    end
    check_eq("relatch_entry", 32'(lat), 32'd7);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("siren_before_rst", 32'(siren), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset", 32'(dut_vec()), 32'd0);
    A = 1'b0; B = 1'b0; C = 1'b0; arm = 1'b0; disarm = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    ra = 1'b0; rb = 1'b0; rc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) ra = ~ra;
      if ($urandom_range(15) == 0) rb = ~rb;
      if ($urandom_range(15) == 0) rc = ~rc;
      cyc(ra, rb, rc, ($urandom_range(9) == 0), ($urandom_range(39) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
